slice_scheduler: RTL and testbench
==================================

# slice_scheduler

Slice scheduler between the hall-effect index sensor and the framebuffer.
- Measures the rotation period in clk_33 cycles and divides it into SLICES equal angular slices.
- Drives enc_position / enc_sync so the framebuffer swaps buffers and fetches the next slice image once per slice.
- Refuses to schedule slices shorter than the framebuffer fill time, and drops lock when the rotor stops.

## Interface
Parameters:
- SLICES, 128: slices per turn; power of two, 2..256.
- PERIOD_WIDTH, 24: width of the period counter and of all period arithmetic.
- MIN_SLICE_CYCLES, 3840: minimum legal slice length in cycles; equals one full 80×48 image fetch.
- TIMEOUT_CYCLES, 2^24-1: period-counter saturation value that declares the rotor stopped; must be ≤ 2^PERIOD_WIDTH-1.

Ports:
- clk_33, in, 1: sole clock. One clock; reset is synchronous and active-low.
- nrst, in, 1: synchronous active-low reset.
- hall_idx, in, 1: raw asynchronous index sensor; rising edge marks angle 0.
- enc_position, out, 8: current slice number; upper bits are 0 when SLICES<256.
- enc_sync, out, 1: one-cycle pulse when enc_position takes a new value.
- locked, out, 1: high while in RUN.
- overspeed, out, 1: sticky; set by a too-short measurement, cleared by the next valid one.
- period, out, PERIOD_WIDTH: last accepted rotation period in cycles.

## Operation
- Input conditioning: hall_idx passes through a 2-FF synchronizer and rising-edge detect to produce idx_pulse. Exactly one idx_pulse per rising edge.
- Period counter (pcnt):
  - Set to 1 in the cycle after an idx_pulse; increments every cycle; saturates at TIMEOUT_CYCLES.
  - On an idx_pulse, meas = pcnt, i.e. the cycle distance between consecutive pulses.
  - slice_len = meas >> log2(SLICES). The remainder is absorbed by the last slice.
- States:
  - IDLE: entered at reset and on timeout. First idx_pulse → MEASURE. No syncs are emitted.
  - MEASURE: on idx_pulse, evaluate slice_len.
    - slice_len < MIN_SLICE_CYCLES: overspeed=1; stay in MEASURE; pcnt restarts.
    - Otherwise: overspeed=0, period=meas, go to RUN, emit sync for position 0.
  - RUN:
    - Slice timer (scnt) reloads with slice_len at each emitted sync and decrements every cycle. When it reaches 1 and enc_position < SLICES-1, emit sync with enc_position+1.
    - After position SLICES-1 is emitted, hold it with no further syncs until the next idx_pulse (late index).
    - idx_pulse arriving before position SLICES-1 (early index) resynchronises to position 0 immediately.
    - idx_pulse whose slice_len < MIN_SLICE_CYCLES: overspeed=1, go to MEASURE, no sync, enc_position holds.
  - Any state: pcnt reaching TIMEOUT_CYCLES → IDLE, locked=0, enc_position holds.
- Simultaneous idx_pulse and scnt expiry: idx_pulse wins, so the next position is 0, never +1.
- Slice lengths are recomputed only at idx_pulse. They are never changed mid-turn.

## Timing
- Reset values: enc_position=0, enc_sync=0, locked=0, overspeed=0, period=0, state IDLE, pcnt=0, scnt=0.
- hall_idx rising edge to idx_pulse: 2–3 cycles, synchronizer-dependent.
- idx_pulse at cycle t → enc_sync=1 and enc_position=0 at t+1, registered. locked rises at t+1 on MEASURE→RUN.
- Subsequent syncs fall at t+1+k·slice_len for k=1..SLICES-1. enc_position changes in the same cycle as enc_sync.
- enc_sync is never high two cycles in a row. enc_sync interval is never below MIN_SLICE_CYCLES except on an early-index resync.
- Reset asserted mid-turn: all outputs return to reset values on the next edge, with no trailing sync.
- Arithmetic:
  - All period math is unsigned, PERIOD_WIDTH wide.
  - The shift is a constant wire select; there is no divider.
  - The comparison against MIN_SLICE_CYCLES is done on the shifted value, zero-extended.

## Structure
- Shared package slice_pkg holds:
  - the state enum {IDLE, MEASURE, RUN};
  - the SLICES/MIN_SLICE_CYCLES defaults, also consumed by the framebuffer top.
- Sub-module: sync_edge (2-FF synchronizer + rising-edge pulse), reused for other async sensor inputs.

## Test plan
Bench parameters: SLICES=4, MIN_SLICE_CYCLES=10, TIMEOUT_CYCLES=1000, PERIOD_WIDTH=16.
- Steady spin: idx edges every 100 cycles.
  - First edge: no sync.
  - Second edge: locked=1, period=100.
  - Syncs at +1, +26, +51, +76 with positions 0,1,2,3; repeats each turn.
- Early index: period 100, then an edge after 60 cycles. Position 2 is followed by sync at position 0; position 3 is never emitted that turn.
- Late index: period 100, then next edge after 140. Position 3 is held for 65 cycles with no extra syncs; then sync at position 0, period=140.
- Overspeed: edges every 30 cycles (slice_len 7 < 10). overspeed=1, locked=0, no syncs. Return to 100-cycle edges → overspeed=0, locked=1.
- Stop: edges cease. Exactly 1000 cycles after the last idx_pulse, locked=0 and no further syncs; the next edge restarts MEASURE.
- Collision and reset: an edge timed to coincide with scnt expiry yields position 0. nrst low mid-turn gives all outputs at 0 next cycle.

Source files
------------

// File: rtl/slice_pkg.sv
`default_nettype none
// slice_pkg -- scheduler state encoding and slice defaults shared with the framebuffer top. rev 1.0
package slice_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    RUN     = 2'd2
  } state_e;

  localparam int SLICES_DEF           = 128;
  localparam int MIN_SLICE_CYCLES_DEF = 3840;

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// sync_edge -- 2-FF synchronizer followed by a one-cycle rising-edge pulse. rev 1.0
module sync_edge (
  input  logic clk_i,
  input  logic nrst_i,
  input  logic async_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse_o = sync_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/slice_scheduler.sv
`default_nettype none
// slice_scheduler -- measures rotor period from the index sensor and paces per-slice
// enc_position/enc_sync updates for the framebuffer. rev 1.0
module slice_scheduler
  import slice_pkg::*;
#(
  parameter int SLICES           = SLICES_DEF,
  parameter int PERIOD_WIDTH     = 24,
  parameter int MIN_SLICE_CYCLES = MIN_SLICE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES   = (1 << 24) - 1
) (
  input  logic                    clk_33,
  input  logic                    nrst,
  input  logic                    hall_idx,
  output logic [7:0]              enc_position,
  output logic                    enc_sync,
  output logic                    locked,
  output logic                    overspeed,
  output logic [PERIOD_WIDTH-1:0] period
);

  localparam int                      c_shift    = $clog2(SLICES);
  localparam logic [PERIOD_WIDTH-1:0] c_min_len  = PERIOD_WIDTH'(MIN_SLICE_CYCLES);
  localparam logic [PERIOD_WIDTH-1:0] c_timeout  = PERIOD_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [PERIOD_WIDTH-1:0] c_one      = PERIOD_WIDTH'(1);
  localparam logic [7:0]              c_last_pos = 8'(SLICES - 1);

  state_e                  state_q,  state_d;
  logic [PERIOD_WIDTH-1:0] pcnt_q,   pcnt_d;
  logic [PERIOD_WIDTH-1:0] scnt_q,   scnt_d;
  logic [PERIOD_WIDTH-1:0] slen_q,   slen_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [7:0]              pos_q,    pos_d;
  logic                    sync_q,   sync_d;
  logic                    over_q,   over_d;

  logic                    w_idx_pulse;
  logic [PERIOD_WIDTH-1:0] w_slice_len;
  logic                    w_too_short;

  sync_edge u_hall_sync (
    .clk_i   (clk_33),
    .nrst_i  (nrst),
    .async_i (hall_idx),
    .pulse_o (w_idx_pulse)
  );

  // pcnt already holds the distance to the previous pulse, so it is the measurement.
  assign w_slice_len = {{c_shift{1'b0}}, pcnt_q[PERIOD_WIDTH-1:c_shift]};
  assign w_too_short = (w_slice_len < c_min_len);

  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    scnt_d   = scnt_q;
    slen_d   = slen_q;
    period_d = period_q;
    pos_d    = pos_q;
    sync_d   = 1'b0;
    over_d   = over_q;

    if (pcnt_q != c_timeout) pcnt_d = pcnt_q + c_one;
    if (scnt_q != '0)        scnt_d = scnt_q - c_one;

    if (w_idx_pulse) begin
      pcnt_d = c_one;
      case (state_q)
        IDLE: state_d = MEASURE;
        default: begin
          if (w_too_short) begin
            over_d  = 1'b1;
            state_d = MEASURE;
          end else begin
            over_d   = 1'b0;
            period_d = pcnt_q;
            slen_d   = w_slice_len;
            scnt_d   = w_slice_len;
            pos_d    = 8'd0;
            sync_d   = 1'b1;
            state_d  = RUN;
          end
        end
      endcase
    end else if (pcnt_d == c_timeout) begin
      state_d = IDLE;
    end else if ((state_q == RUN) && (scnt_q == c_one) && (pos_q != c_last_pos)) begin
      // The last slice has no expiry sync; it simply runs until the next index.
      pos_d  = pos_q + 8'd1;
      sync_d = 1'b1;
      scnt_d = slen_q;
    end
  end

  always_ff @(posedge clk_33) begin
    if (!nrst) begin
      state_q  <= IDLE;
      pcnt_q   <= '0;
      scnt_q   <= '0;
      slen_q   <= '0;
      period_q <= '0;
      pos_q    <= 8'd0;
      sync_q   <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      scnt_q   <= scnt_d;
      slen_q   <= slen_d;
      period_q <= period_d;
      pos_q    <= pos_d;
      sync_q   <= sync_d;
      over_q   <= over_d;
    end
  end

  assign enc_position = pos_q;
  assign enc_sync     = sync_q;
  assign locked       = (state_q == RUN);
  assign overspeed    = over_q;
  assign period       = period_q;

endmodule
`default_nettype wire

// File: tb/tb_slice_scheduler.sv
`default_nettype none
// tb_slice_scheduler -- table vectors, hand corner sequences and random index timing
// checked every cycle against a schedule-arithmetic reference model. rev 1.0
module tb_slice_scheduler;

  localparam int B_SLICES = 4;
  localparam int B_PW     = 16;
  localparam int B_MIN    = 10;
  localparam int B_TO     = 1000;

  localparam int M_IDLE = 0;
  localparam int M_MEAS = 1;
  localparam int M_RUN  = 2;

  logic            clk_33 = 1'b0;
  logic            nrst;
  logic            hall_idx;
  logic [7:0]      enc_position;
  logic            enc_sync;
  logic            locked;
  logic            overspeed;
  logic [B_PW-1:0] period;

  slice_scheduler #(
    .SLICES           (B_SLICES),
    .PERIOD_WIDTH     (B_PW),
    .MIN_SLICE_CYCLES (B_MIN),
    .TIMEOUT_CYCLES   (B_TO)
  ) dut (
    .clk_33       (clk_33),
    .nrst         (nrst),
    .hall_idx     (hall_idx),
    .enc_position (enc_position),
    .enc_sync     (enc_sync),
    .locked       (locked),
    .overspeed    (overspeed),
    .period       (period)
  );

  always #5 clk_33 = ~clk_33;

  typedef struct {
    int              gap;
    logic [7:0]      pos;
    logic            sync;
    logic            lock;
    logic            over;
    logic [B_PW-1:0] per;
  } vec_t;

  vec_t vecs [11];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: outputs derived from pulse times and the accepted slice length.
  int       cyc;
  int       m_state, m_last, m_anchor, m_len, m_pos, m_period;
  bit       m_sync, m_over;
  logic [3:0] hist;

  task automatic model_reset();
    m_state  = M_IDLE;
    m_pos    = 0;
    m_sync   = 1'b0;
    m_over   = 1'b0;
    m_period = 0;
    m_len    = 1;
    m_anchor = 0;
    hist     = 4'b0;
    m_last   = cyc;
  endtask

  task automatic model_step(input int n, input logic p);
    int el, d, k;
    el = n - m_last;
    if (el > B_TO) el = B_TO;
    m_sync = 1'b0;
    if (p) begin
      if (m_state == M_IDLE) begin
        m_state = M_MEAS;
      end else if (el / B_SLICES < B_MIN) begin
        m_over  = 1'b1;
        m_state = M_MEAS;
      end else begin
        m_over   = 1'b0;
        m_period = el;
        m_len    = el / B_SLICES;
        m_anchor = n;
        m_state  = M_RUN;
        m_sync   = 1'b1;
        m_pos    = 0;
      end
      m_last = n;
    end else if (n + 1 - m_last >= B_TO) begin
      m_state = M_IDLE;
    end else if (m_state == M_RUN) begin
      d = n - m_anchor;
      k = d / m_len;
      if ((d % m_len == 0) && (k >= 1) && (k <= B_SLICES - 1)) begin
        m_sync = 1'b1;
        m_pos  = k;
      end
    end
  endtask

  task automatic tick(input logic h);
    int   n;
    logic p;
    hall_idx = h;
    @(posedge clk_33);
    n   = cyc;
    cyc = cyc + 1;
    if (!nrst) begin
      model_reset();
    end else begin
      hist = {hist[2:0], h};
      p    = hist[2] & ~hist[3];
      model_step(n, p);
    end
    @(negedge clk_33);
    n_checks++;
    if ((enc_position !== 8'(m_pos)) || (enc_sync !== m_sync) ||
        (locked !== (m_state == M_RUN)) || (overspeed !== m_over) ||
        (period !== B_PW'(m_period))) begin
      n_fail++;
      $display("FAIL model cyc=%0d: got pos=%0d sync=%0b locked=%0b over=%0b period=%0d, want pos=%0d sync=%0b locked=%0b over=%0b period=%0d",
               cyc, enc_position, enc_sync, locked, overspeed, period,
               m_pos, m_sync, (m_state == M_RUN), m_over, m_period);
    end
  endtask

  task automatic hall_pulse(input int lows, input int highs);
    repeat (lows) tick(1'b0);
    repeat (highs) tick(1'b1);
  endtask

  task automatic check_exp(input string name, input logic [7:0] pos, input logic sync,
                           input logic lock, input logic over, input logic [B_PW-1:0] per);
    n_checks++;
    if ((enc_position !== pos) || (enc_sync !== sync) || (locked !== lock) ||
        (overspeed !== over) || (period !== per)) begin
      n_fail++;
      $display("FAIL %s: got pos=%0d sync=%0b locked=%0b over=%0b period=%0d, want pos=%0d sync=%0b locked=%0b over=%0b period=%0d",
               name, enc_position, enc_sync, locked, overspeed, period, pos, sync, lock, over, per);
    end
  endtask

  initial begin
    int prev_w, w, gap;

    // gap = cycles since previous hall rising edge; expected values one cycle after the index.
    vecs[0]  = '{100, 8'd0, 1'b0, 1'b0, 1'b0, 16'd0};    // first edge: MEASURE only
    vecs[1]  = '{100, 8'd0, 1'b1, 1'b1, 1'b0, 16'd100};  // lock
    vecs[2]  = '{100, 8'd0, 1'b1, 1'b1, 1'b0, 16'd100};
    vecs[3]  = '{60,  8'd0, 1'b1, 1'b1, 1'b0, 16'd60};   // early index
    vecs[4]  = '{100, 8'd0, 1'b1, 1'b1, 1'b0, 16'd100};
    vecs[5]  = '{140, 8'd0, 1'b1, 1'b1, 1'b0, 16'd140};  // late index
    vecs[6]  = '{30,  8'd0, 1'b0, 1'b0, 1'b1, 16'd140};  // overspeed drops lock
    vecs[7]  = '{30,  8'd0, 1'b0, 1'b0, 1'b1, 16'd140};
    vecs[8]  = '{100, 8'd0, 1'b1, 1'b1, 1'b0, 16'd100};  // recovery
    vecs[9]  = '{100, 8'd0, 1'b1, 1'b1, 1'b0, 16'd100};
    vecs[10] = '{50,  8'd0, 1'b1, 1'b1, 1'b0, 16'd50};   // index coincides with slice expiry

    cyc      = 0;
    nrst     = 1'b0;
    hall_idx = 1'b0;
    model_reset();
    @(negedge clk_33);
    repeat (3) tick(1'b0);
    check_exp("reset", 8'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    nrst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      hall_pulse(vecs[i].gap - 3, 3);
      check_exp($sformatf("vec%0d", i), vecs[i].pos, vecs[i].sync, vecs[i].lock,
                vecs[i].over, vecs[i].per);
    end

    // Rotor stop: last index was one cycle ago, lock must fall exactly 1000 cycles after it.
    repeat (998) tick(1'b0);
    check_exp("stop_pre", 8'd3, 1'b0, 1'b1, 1'b0, 16'd50);
    tick(1'b0);
    check_exp("stop_timeout", 8'd3, 1'b0, 1'b0, 1'b0, 16'd50);
    hall_pulse(20, 3);
    check_exp("restart_idle", 8'd3, 1'b0, 1'b0, 1'b0, 16'd50);
    hall_pulse(97, 3);
    check_exp("restart_lock", 8'd0, 1'b1, 1'b1, 1'b0, 16'd100);

    // Reset on the edge that would otherwise emit position 2.
    repeat (49) tick(1'b0);
    check_exp("pre_reset", 8'd1, 1'b0, 1'b1, 1'b0, 16'd100);
    nrst = 1'b0;
    tick(1'b0);
    check_exp("reset_mid", 8'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    nrst = 1'b1;
    repeat (5) tick(1'b0);

    prev_w = 0;
    for (int i = 0; i < 30; i++) begin
      w   = int'($urandom_range(1, 4));
      gap = ($urandom_range(0, 7) == 0) ? 1100 : int'($urandom_range(25, 170));
      hall_pulse(gap - prev_w, w);
      prev_w = w;
    end
    repeat (1100) tick(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
